// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - stage indices, FSM state type and priority helper shared by pipeline_ctrl
package pipe_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Stage indices are signed so that "no stage" can be carried as -1 through compares.
    localparam int IDX_W = 8;
    typedef logic signed [IDX_W-1:0] stg_idx_t;
    localparam stg_idx_t IDX_NONE = -8'sd1;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        RUN        = 2'd1,
        FLUSH_PEND = 2'd2
    } pipe_state_t;

    function automatic int highest_set(input logic [31:0] vec);
        int idx;
        idx = -1;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - request/control bundle between the core stages and pipeline_ctrl
// Perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int PERF_CNT_W = 32
);

    logic                  fetch_valid;
    logic [NUM_STAGES-1:0] stall_req;
    logic [NUM_STAGES-1:0] flush_req;
    logic [NUM_STAGES-1:0] stage_clk_en;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  busy;

    if (NUM_STAGES < 2 || PERF_CNT_W < 1) begin : g_bad_cfg
        $error("pipeline_ctrl_if: unsupported parameter set");
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_cyc;
    logic [PERF_CNT_W-1:0] perf_flush_cnt;
    logic [PERF_CNT_W-1:0] perf_retire_cnt;

    modport master (
        output fetch_valid, stall_req, flush_req,
        input  stage_clk_en, stage_valid, stage_flush, busy,
        input  perf_stall_cyc, perf_flush_cnt, perf_retire_cnt
    );

    modport slave (
        input  fetch_valid, stall_req, flush_req,
        output stage_clk_en, stage_valid, stage_flush, busy,
        output perf_stall_cyc, perf_flush_cnt, perf_retire_cnt
    );
`else
    modport master (
        output fetch_valid, stall_req, flush_req,
        input  stage_clk_en, stage_valid, stage_flush, busy
    );

    modport slave (
        input  fetch_valid, stall_req, flush_req,
        output stage_clk_en, stage_valid, stage_flush, busy
    );
`endif

endinterface

// File: rtl/pipeline_ctrl_prio_enc.sv
// rtl/pipeline_ctrl_prio_enc.sv - highest-set-bit encoder, returns -1 for an all-zero vector
module pipe_prio_enc
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] vec_i,
    output stg_idx_t     idx_o
);

    logic [31:0] vec_ext;

    always_comb begin
        vec_ext        = '0;
        vec_ext[W-1:0] = vec_i;
        idx_o          = stg_idx_t'(highest_set(vec_ext));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer driving per-stage clk_en, valid and flush
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES        = 5,
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int PERF_CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    localparam int                    HOLD_W       = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_INIT    = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam stg_idx_t              LAST_IDX     = stg_idx_t'(NUM_STAGES - 1);
    localparam stg_idx_t              WB_STALL_IDX = stg_idx_t'(NUM_STAGES - 2);
    localparam logic [NUM_STAGES-1:0] FLUSH_MASK   = ~NUM_STAGES'(1);

    if (NUM_STAGES < 2 || NUM_STAGES > 32 || RESET_HOLD_CYCLES < 1 || PERF_CNT_W < 1) begin : g_bad_cfg
        $error("pipeline_ctrl: unsupported parameter set");
    end

    pipe_state_t           state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [NUM_STAGES-1:0] valid_q, valid_d;
    stg_idx_t              pend_q, pend_d;

    stg_idx_t              s_raw, f_live, s_eff, f_merge;
    logic [NUM_STAGES-1:0] stalled, flush_vec, clk_en;
    logic                  running, flush_take;

    pipe_prio_enc #(.W(NUM_STAGES)) u_stall_enc (
        .vec_i (bus.stall_req),
        .idx_o (s_raw)
    );

    pipe_prio_enc #(.W(NUM_STAGES)) u_flush_enc (
        .vec_i (bus.flush_req & FLUSH_MASK),
        .idx_o (f_live)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        running    = (state_q != HOLD);
        s_eff      = IDX_NONE;
        f_merge    = IDX_NONE;

        if (running) begin
            // A writeback stall request freezes everything upstream and bubbles writeback.
            s_eff   = (s_raw == LAST_IDX) ? WB_STALL_IDX : s_raw;
            f_merge = (f_live > pend_q) ? f_live : pend_q;
        end
        // Flush-vs-stall priority uses the raw stall index, so a writeback flush
        // raised together with a writeback stall waits for the stall to drop.
        flush_take = running && (f_merge > s_raw);

        for (int k = 0; k < NUM_STAGES; k++) begin
            flush_vec[k] = flush_take && (k < int'(f_merge));
            stalled[k]   = !flush_take && (k <= int'(s_eff));
        end

        clk_en = running ? (valid_q & ~stalled & ~flush_vec) : '0;

        if (running) begin
            valid_d[0] = stalled[0] ? valid_q[0] : (bus.fetch_valid & ~flush_vec[0]);
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (!stalled[k]) begin
                    valid_d[k] = clk_en[k-1];
                end
            end
        end

        unique case (state_q)
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                if (flush_take) begin
                    pend_d  = IDX_NONE;
                    state_d = RUN;
                end else if (f_merge > stg_idx_t'(0)) begin
                    pend_d  = f_merge;
                    state_d = FLUSH_PEND;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            hold_cnt_q <= HOLD_INIT;
            valid_q    <= '0;
            pend_q     <= IDX_NONE;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.stage_clk_en = clk_en;
    assign bus.stage_valid  = valid_q;
    assign bus.stage_flush  = flush_vec;
    assign bus.busy         = (state_q != RUN);

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_q, perf_flush_q, perf_retire_q;
    logic                  stall_any;

    assign stall_any = |stalled;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
            perf_retire_q <= '0;
        end else if (running) begin
            if (stall_any) begin
                perf_stall_q <= perf_stall_q + PERF_CNT_W'(1);
            end
            if (flush_take) begin
                perf_flush_q <= perf_flush_q + PERF_CNT_W'(1);
            end
            if (clk_en[NUM_STAGES-1]) begin
                perf_retire_q <= perf_retire_q + PERF_CNT_W'(1);
            end
        end
    end

    assign bus.perf_stall_cyc  = perf_stall_q;
    assign bus.perf_flush_cnt  = perf_flush_q;
    assign bus.perf_retire_cnt = perf_retire_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl (perf tests need PIPE_CTRL_PERF_EN)
module tb_pipeline_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipeline_ctrl_if #(.NUM_STAGES(5), .PERF_CNT_W(32)) bus ();

    pipeline_ctrl #(
        .NUM_STAGES        (5),
        .RESET_HOLD_CYCLES (4),
        .PERF_CNT_W        (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({bus.stage_clk_en, bus.stage_flush, bus.stage_valid, bus.busy} !== {15'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_out: got clk_en=%b flush=%b valid=%b busy=%b want 0/0/0/1",
                     bus.stage_clk_en, bus.stage_flush, bus.stage_valid, bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            rst_n = 1'b1;
            bus.stall_req = (i == 1) ? 5'b00100 : 5'b0;
            bus.flush_req = (i == 2) ? 5'b01000 : 5'b0;
            @(negedge clk);
            n_cmp++;
            if ({bus.stage_clk_en, bus.stage_flush, bus.busy} !== {10'b0, 1'b1}) begin
                n_err++;
                $display("FAIL hold_cyc%0d: got clk_en=%b flush=%b busy=%b want 0/0/1",
                         i, bus.stage_clk_en, bus.stage_flush, bus.busy);
            end
        end
        tick();
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.stage_valid, bus.stage_clk_en} !== 11'b0) begin
            n_err++;
            $display("FAIL run_entry: got busy=%b valid=%b clk_en=%b want 0/0/0",
                     bus.busy, bus.stage_valid, bus.stage_clk_en);
        end
        for (int i = 0; i < 5; i++) begin
            logic [4:0] ev;
            ev = 5'((1 << (i + 1)) - 1);
            tick();
            @(negedge clk);
            n_cmp++;
            if (bus.stage_valid !== ev || bus.stage_clk_en !== ev) begin
                n_err++;
                $display("FAIL fill_%0d: got valid=%b clk_en=%b want %b", i, bus.stage_valid, bus.stage_clk_en, ev);
            end
        end
    endtask

    task automatic test_stall();
        logic [4:0] ev [0:5];
        logic [4:0] ec [0:5];
        ev = '{5'b11111, 5'b10111, 5'b00111, 5'b00111, 5'b01111, 5'b11111};
        ec = '{5'b11000, 5'b10000, 5'b00000, 5'b00111, 5'b01111, 5'b11111};
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.stall_req = (i < 3) ? 5'b00100 : 5'b0;
            @(negedge clk);
            n_cmp++;
            if (bus.stage_valid !== ev[i] || bus.stage_clk_en !== ec[i] || bus.stage_flush !== 5'b0) begin
                n_err++;
                $display("FAIL stall_%0d: got valid=%b clk_en=%b flush=%b want %b/%b/00000",
                         i, bus.stage_valid, bus.stage_clk_en, bus.stage_flush, ev[i], ec[i]);
            end
        end
    endtask

    task automatic test_flush();
        tick();
        bus.flush_req = 5'b01000;
        @(negedge clk);
        n_cmp++;
        if (bus.stage_flush !== 5'b00111 || bus.stage_clk_en !== 5'b11000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_apply: got flush=%b clk_en=%b busy=%b want 00111/11000/0",
                     bus.stage_flush, bus.stage_clk_en, bus.busy);
        end
        tick();
        bus.flush_req = 5'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b10000 || bus.stage_flush !== 5'b0) begin
            n_err++;
            $display("FAIL flush_next: got valid=%b flush=%b want 10000/00000", bus.stage_valid, bus.stage_flush);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b00001) begin
            n_err++;
            $display("FAIL flush_refill: got valid=%b want 00001", bus.stage_valid);
        end
        repeat (4) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b11111) begin
            n_err++;
            $display("FAIL flush_full: got valid=%b want 11111", bus.stage_valid);
        end
    endtask

    task automatic test_defer();
        tick();
        bus.stall_req = 5'b01000;
        bus.flush_req = 5'b00100;
        @(negedge clk);
        n_cmp++;
        if (bus.stage_flush !== 5'b0 || bus.stage_clk_en !== 5'b10000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL defer_req: got flush=%b clk_en=%b busy=%b want 00000/10000/0",
                     bus.stage_flush, bus.stage_clk_en, bus.busy);
        end
        tick();
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.stage_flush !== 5'b00011 || bus.stage_clk_en !== 5'b01100
            || bus.stage_valid !== 5'b01111) begin
            n_err++;
            $display("FAIL defer_apply: got busy=%b flush=%b clk_en=%b valid=%b want 1/00011/01100/01111",
                     bus.busy, bus.stage_flush, bus.stage_clk_en, bus.stage_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.stage_flush !== 5'b0 || bus.stage_valid !== 5'b11000) begin
            n_err++;
            $display("FAIL defer_after: got busy=%b flush=%b valid=%b want 0/00000/11000",
                     bus.busy, bus.stage_flush, bus.stage_valid);
        end
        repeat (5) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b11111) begin
            n_err++;
            $display("FAIL defer_full: got valid=%b want 11111", bus.stage_valid);
        end
    endtask

    task automatic test_pend_replace();
        tick();
        bus.stall_req = 5'b01000;
        bus.flush_req = 5'b00100;
        tick();
        bus.stall_req = 5'b10000;
        bus.flush_req = 5'b10000;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.stage_flush !== 5'b0 || bus.stage_clk_en !== 5'b0) begin
            n_err++;
            $display("FAIL repl_hold: got busy=%b flush=%b clk_en=%b want 1/00000/00000",
                     bus.busy, bus.stage_flush, bus.stage_clk_en);
        end
        tick();
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.stage_flush !== 5'b01111 || bus.stage_valid !== 5'b01111) begin
            n_err++;
            $display("FAIL repl_apply: got busy=%b flush=%b valid=%b want 1/01111/01111",
                     bus.busy, bus.stage_flush, bus.stage_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.stage_flush !== 5'b0 || bus.stage_valid !== 5'b0) begin
            n_err++;
            $display("FAIL repl_once: got busy=%b flush=%b valid=%b want 0/00000/00000",
                     bus.busy, bus.stage_flush, bus.stage_valid);
        end
        repeat (5) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b11111) begin
            n_err++;
            $display("FAIL repl_full: got valid=%b want 11111", bus.stage_valid);
        end
    endtask

    task automatic test_wb_stall();
        tick();
        bus.stall_req = 5'b10000;
        @(negedge clk);
        n_cmp++;
        if (bus.stage_clk_en !== 5'b10000 || bus.stage_flush !== 5'b0) begin
            n_err++;
            $display("FAIL wb_stall: got clk_en=%b flush=%b want 10000/00000", bus.stage_clk_en, bus.stage_flush);
        end
        tick();
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b00001;
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b01111 || bus.stage_clk_en !== 5'b01111 || bus.stage_flush !== 5'b0
            || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL wb_bubble_flush0: got valid=%b clk_en=%b flush=%b busy=%b want 01111/01111/00000/0",
                     bus.stage_valid, bus.stage_clk_en, bus.stage_flush, bus.busy);
        end
        tick();
        bus.flush_req = 5'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.stage_valid !== 5'b11111) begin
            n_err++;
            $display("FAIL wb_refill: got valid=%b want 11111", bus.stage_valid);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.stall_req = 5'b01000;
        bus.flush_req = 5'b00100;
        tick();
        rst_n = 1'b0;
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.stage_valid, bus.stage_clk_en, bus.stage_flush} !== {1'b1, 15'b0}) begin
            n_err++;
            $display("FAIL midrst_out: got busy=%b valid=%b clk_en=%b flush=%b want 1/0/0/0",
                     bus.busy, bus.stage_valid, bus.stage_clk_en, bus.stage_flush);
        end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.stage_clk_en !== 5'b0) begin
            n_err++;
            $display("FAIL midrst_hold4: got busy=%b clk_en=%b want 1/00000", bus.busy, bus.stage_clk_en);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.stage_flush !== 5'b0 || bus.stage_valid !== 5'b0) begin
            n_err++;
            $display("FAIL midrst_pend_gone: got busy=%b flush=%b valid=%b want 0/00000/00000",
                     bus.busy, bus.stage_flush, bus.stage_valid);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        tick();
        rst_n = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.perf_stall_cyc, bus.perf_flush_cnt, bus.perf_retire_cnt} !== 96'b0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0",
                     bus.perf_stall_cyc, bus.perf_flush_cnt, bus.perf_retire_cnt);
        end
        repeat (3) tick();
        repeat (5) tick();
        repeat (6) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.stall_req = 5'b00001;
        end
        tick();
        bus.stall_req = 5'b0;
        bus.flush_req = 5'b00010;
        tick();
        bus.flush_req = 5'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.perf_stall_cyc !== 32'd3 || bus.perf_flush_cnt !== 32'd1 || bus.perf_retire_cnt !== 32'd10) begin
            n_err++;
            $display("FAIL perf_counts: got %0d/%0d/%0d want 3/1/10",
                     bus.perf_stall_cyc, bus.perf_flush_cnt, bus.perf_retire_cnt);
        end
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.perf_stall_cyc, bus.perf_flush_cnt, bus.perf_retire_cnt} !== 96'b0
            || bus.stage_valid !== 5'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL perf_midrst: got %0d/%0d/%0d valid=%b busy=%b want 0/0/0/00000/1",
                     bus.perf_stall_cyc, bus.perf_flush_cnt, bus.perf_retire_cnt, bus.stage_valid, bus.busy);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stall();
        test_flush();
        test_defer();
        test_pend_replace();
        test_wb_stall();
        test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
